// File: rtl/uart_fpu_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fpu_uart_pkg
// Shared types and constants for the UART <-> FPU command framer.
//   fpu_op_t      : FPU operation encoding carried in the opcode byte
//   frame_state_t : framer state machine states
//   put_lane      : writes one big-endian byte lane of a 32-bit word
// ---------------------------------------------------------------------------
package fpu_uart_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } fpu_op_t;

    typedef enum logic [2:0] {
        RX_OP,
        RX_A,
        RX_B,
        ISSUE,
        WAIT_FPU,
        TX_LOAD,
        TX_WAIT_HI,
        TX_WAIT_LO
    } frame_state_t;

    localparam int OPERAND_BYTES = 4;
    localparam int RESULT_BYTES  = 4;

    // Lane 0 is the most significant byte, so bytes arrive MSB first.
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[31:24] = data;
            2'd1:    r[23:16] = data;
            2'd2:    r[15:8]  = data;
            default: r[7:0]   = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_fpu_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_fpu_frame_ctrl_if
// Bundles the UART receive/transmit handshakes and the FPU request/result
// signals seen by the framer.
//   slave  : the framer (consumes rx bytes / FPU results, drives tx + FPU req)
//   master : the surrounding UART + FPU environment
// ---------------------------------------------------------------------------
interface uart_fpu_frame_ctrl_if;
    import fpu_uart_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_busy;
    logic        rx_err;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    fpu_op_t     fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        busy;
    logic        drop_pulse;

    modport slave (
        input  rx_data, rx_busy, rx_err, tx_busy, fpu_done, fpu_result,
        output tx_data, tx_en, fpu_op, fpu_a, fpu_b, fpu_start, busy, drop_pulse
    );

    modport master (
        output rx_data, rx_busy, rx_err, tx_busy, fpu_done, fpu_result,
        input  tx_data, tx_en, fpu_op, fpu_a, fpu_b, fpu_start, busy, drop_pulse
    );

endinterface

// File: rtl/uart_fpu_frame_ctrl_byte_strobe.sv
// ---------------------------------------------------------------------------
// uart_byte_strobe
// Turns the receiver busy flag into a one-cycle byte strobe and measures the
// idle gap between strobes while a frame is being assembled.
//   clk, reset  : clock, asynchronous active-low reset
//   rx_busy     : receiver busy; a 1->0 transition completes a byte
//   count_en    : high while the framer is collecting operand bytes
//   byte_strobe : one cycle, registered, one cycle after rx_busy falls
//   timeout     : idle gap reached RX_TIMEOUT (never fires when RX_TIMEOUT=0)
// ---------------------------------------------------------------------------
module uart_byte_strobe #(
    parameter logic [31:0] RX_TIMEOUT = 32'd200000
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_busy,
    input  logic count_en,
    output logic byte_strobe,
    output logic timeout
);

    logic        rx_busy_q;
    logic [31:0] idle_cnt;

    // Edge detector and idle counter. The counter saturates at RX_TIMEOUT and
    // is held at zero outside operand collection so each frame starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_busy_q   <= 1'b0;
            byte_strobe <= 1'b0;
            idle_cnt    <= 32'd0;
        end else begin
            rx_busy_q   <= rx_busy;
            byte_strobe <= rx_busy_q & ~rx_busy;
            if (!count_en || byte_strobe) begin
                idle_cnt <= 32'd0;
            end else if (idle_cnt != RX_TIMEOUT) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

    // A strobe in the same cycle suppresses the timeout.
    assign timeout = (RX_TIMEOUT != 32'd0) && count_en && !byte_strobe &&
                     (idle_cnt == RX_TIMEOUT);

endmodule

// File: rtl/uart_fpu_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_fpu_frame_ctrl
// Assembles a 9-byte command frame (opcode, operand A, operand B, big-endian)
// from the UART receiver, issues one FPU operation, and serialises the 32-bit
// result back through the UART transmitter. An invalid opcode is answered
// with a single ERR_BYTE.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : uart_fpu_frame_ctrl_if.slave (rx, tx, FPU, busy, drop_pulse)
// ---------------------------------------------------------------------------
module uart_fpu_frame_ctrl
    import fpu_uart_pkg::*;
#(
    parameter logic [31:0] RX_TIMEOUT = 32'd200000,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_fpu_frame_ctrl_if.slave  bus
);

    localparam logic [1:0] LAST_LANE   = 2'(OPERAND_BYTES - 1);
    localparam logic [2:0] RESULT_CNT  = 3'(RESULT_BYTES);

    frame_state_t state,      state_next;
    logic [1:0]   idx,        idx_next;
    logic [2:0]   count,      count_next;
    fpu_op_t      op_q,       op_next;
    logic [31:0]  a_q,        a_next;
    logic [31:0]  b_q,        b_next;
    logic [31:0]  shift_q,    shift_next;
    fpu_op_t      fpu_op_r,   fpu_op_next;
    logic [31:0]  fpu_a_r,    fpu_a_next;
    logic [31:0]  fpu_b_r,    fpu_b_next;
    logic         fpu_start_r, fpu_start_next;
    logic [7:0]   tx_data_r,  tx_data_next;
    logic         tx_en_r,    tx_en_next;
    logic         drop_r,     drop_next;

    logic byte_strobe;
    logic timeout;
    logic count_en;

    assign count_en = (state == RX_A) || (state == RX_B);

    uart_byte_strobe #(
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_strobe (
        .clk         (clk),
        .reset       (reset),
        .rx_busy     (bus.rx_busy),
        .count_en    (count_en),
        .byte_strobe (byte_strobe),
        .timeout     (timeout)
    );

    // State and datapath registers. Operands are assembled in a_q/b_q and
    // only copied to the FPU outputs in ISSUE, so an aborted frame leaves the
    // previously issued operands visible to the FPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RX_OP;
            idx         <= 2'd0;
            count       <= 3'd0;
            op_q        <= ADD;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            shift_q     <= 32'd0;
            fpu_op_r    <= ADD;
            fpu_a_r     <= 32'd0;
            fpu_b_r     <= 32'd0;
            fpu_start_r <= 1'b0;
            tx_data_r   <= 8'd0;
            tx_en_r     <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            count       <= count_next;
            op_q        <= op_next;
            a_q         <= a_next;
            b_q         <= b_next;
            shift_q     <= shift_next;
            fpu_op_r    <= fpu_op_next;
            fpu_a_r     <= fpu_a_next;
            fpu_b_r     <= fpu_b_next;
            fpu_start_r <= fpu_start_next;
            tx_data_r   <= tx_data_next;
            tx_en_r     <= tx_en_next;
            drop_r      <= drop_next;
        end
    end

    // Next-state and next-output logic. Pulses default low; everything else
    // holds. In RX_A/RX_B a framing error aborts even if a strobe coincides,
    // while a strobe beats a coinciding timeout.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        count_next     = count;
        op_next        = op_q;
        a_next         = a_q;
        b_next         = b_q;
        shift_next     = shift_q;
        fpu_op_next    = fpu_op_r;
        fpu_a_next     = fpu_a_r;
        fpu_b_next     = fpu_b_r;
        fpu_start_next = 1'b0;
        tx_data_next   = tx_data_r;
        tx_en_next     = 1'b0;
        drop_next      = 1'b0;

        case (state)
            RX_OP: begin
                if (byte_strobe) begin
                    if (bus.rx_data[7:2] != 6'd0) begin
                        shift_next = {ERR_BYTE, 24'd0};
                        count_next = 3'd1;
                        drop_next  = 1'b1;
                        state_next = TX_LOAD;
                    end else begin
                        op_next    = fpu_op_t'(bus.rx_data[1:0]);
                        idx_next   = 2'd0;
                        state_next = RX_A;
                    end
                end
            end

            RX_A, RX_B: begin
                if (bus.rx_err) begin
                    drop_next  = 1'b1;
                    idx_next   = 2'd0;
                    state_next = RX_OP;
                end else if (byte_strobe) begin
                    if (state == RX_A) begin
                        a_next = put_lane(a_q, idx, bus.rx_data);
                    end else begin
                        b_next = put_lane(b_q, idx, bus.rx_data);
                    end
                    if (idx == LAST_LANE) begin
                        idx_next   = 2'd0;
                        state_next = (state == RX_A) ? RX_B : ISSUE;
                    end else begin
                        idx_next = idx + 2'd1;
                    end
                end else if (timeout) begin
                    drop_next  = 1'b1;
                    idx_next   = 2'd0;
                    state_next = RX_OP;
                end
            end

            ISSUE: begin
                fpu_op_next    = op_q;
                fpu_a_next     = a_q;
                fpu_b_next     = b_q;
                fpu_start_next = 1'b1;
                state_next     = WAIT_FPU;
            end

            WAIT_FPU: begin
                if (bus.fpu_done) begin
                    shift_next = bus.fpu_result;
                    count_next = RESULT_CNT;
                    state_next = TX_LOAD;
                end
            end

            TX_LOAD: begin
                if (!bus.tx_busy) begin
                    tx_data_next = shift_q[31:24];
                    tx_en_next   = 1'b1;
                    state_next   = TX_WAIT_HI;
                end
            end

            TX_WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_next = TX_WAIT_LO;
                end
            end

            TX_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    count_next = count - 3'd1;
                    if (count == 3'd1) begin
                        state_next = RX_OP;
                    end else begin
                        shift_next = {shift_q[23:0], 8'd0};
                        state_next = TX_LOAD;
                    end
                end
            end

            default: begin
                state_next = RX_OP;
            end
        endcase

        // Bytes arriving while a command is in flight are thrown away.
        if (byte_strobe && !(state inside {RX_OP, RX_A, RX_B})) begin
            drop_next = 1'b1;
        end
    end

    assign bus.fpu_op     = fpu_op_r;
    assign bus.fpu_a      = fpu_a_r;
    assign bus.fpu_b      = fpu_b_r;
    assign bus.fpu_start  = fpu_start_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.tx_en      = tx_en_r;
    assign bus.drop_pulse = drop_r;
    assign bus.busy       = (state != RX_OP);

endmodule

// File: tb/tb_uart_fpu_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_fpu_frame_ctrl
// Directed bench for uart_fpu_frame_ctrl with RX_TIMEOUT=1000. A small
// transmitter model answers tx_en with a busy window; a monitor counts
// pulses and logs transmitted bytes. Each test task checks its own results.
// ---------------------------------------------------------------------------
module tb_uart_fpu_frame_ctrl;
    import fpu_uart_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks   = 0;
    int failures = 0;

    int drop_cnt    = 0;
    int start_cnt   = 0;
    int tx_bad      = 0;
    logic [7:0] tx_q[$];

    uart_fpu_frame_ctrl_if bus();

    uart_fpu_frame_ctrl #(
        .RX_TIMEOUT (32'd1000),
        .ERR_BYTE   (8'hEE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters and transmit log, sampled on the falling edge.
    initial begin
        logic tx_en_prev;
        tx_en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.drop_pulse) drop_cnt++;
            if (bus.fpu_start)  start_cnt++;
            if (bus.tx_en) begin
                tx_q.push_back(bus.tx_data);
                if (bus.tx_busy || tx_en_prev) tx_bad++;
            end
            tx_en_prev = bus.tx_en;
        end
    end

    // Transmitter model: goes busy the cycle after tx_en for 5 cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_en) begin
                @(posedge clk); #1 bus.tx_busy = 1'b1;
                repeat (5) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.rx_busy = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(b[i*8 +: 8]);
    endtask

    task automatic fpu_reply(input logic [31:0] r);
        repeat (2) @(posedge clk);
        #1;
        bus.fpu_result = r;
        bus.fpu_done   = 1'b1;
        @(posedge clk); #1 bus.fpu_done = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_tx(input int n, input string name);
        int cyc;
        cyc = 0;
        while (tx_q.size() < n && cyc < 600) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        checks++;
        if (tx_q.size() < n) begin
            failures++;
            $display("[TB] FAIL %s tx_count: got %0d, expected %0d", name, tx_q.size(), n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.rx_data = 8'd0; bus.rx_busy = 1'b0; bus.rx_err = 1'b0;
        bus.fpu_done = 1'b0; bus.fpu_result = 32'd0;
        settle(3);
        checks++;
        if ({bus.tx_en, bus.fpu_start, bus.busy, bus.drop_pulse} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_pulses: got %b, expected 0000",
                     {bus.tx_en, bus.fpu_start, bus.busy, bus.drop_pulse});
        end
        checks++;
        if ({bus.tx_data, bus.fpu_a, bus.fpu_b, bus.fpu_op} !== 74'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got tx=%h a=%h b=%h op=%0d, expected all 0",
                     bus.tx_data, bus.fpu_a, bus.fpu_b, bus.fpu_op);
        end
        @(posedge clk); #1 reset = 1'b1;
        settle(2);
    endtask

    task automatic test_add_frame;
        int s0, d0;
        logic [7:0] exp[4];
        exp = '{8'h40, 8'h40, 8'h00, 8'h00};
        s0 = start_cnt; d0 = drop_cnt; tx_q.delete();
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000);
        settle(2);
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("[TB] FAIL add_start_count: got %0d, expected 1", start_cnt - s0);
        end
        checks++;
        if (bus.fpu_op !== ADD || bus.fpu_a !== 32'h3F80_0000 || bus.fpu_b !== 32'h4000_0000) begin
            failures++;
            $display("[TB] FAIL add_operands: got op=%0d a=%h b=%h, expected 0 3f800000 40000000",
                     bus.fpu_op, bus.fpu_a, bus.fpu_b);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL add_busy_wait: got %b, expected 1", bus.busy);
        end
        fpu_reply(32'h4040_0000);
        wait_tx(4, "add");
        settle(15);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("[TB] FAIL add_tx_byte%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
        checks++;
        if (tx_bad != 0) begin
            failures++;
            $display("[TB] FAIL add_tx_protocol: got %0d violations, expected 0", tx_bad);
        end
        checks++;
        if (bus.busy !== 1'b0 || drop_cnt != d0) begin
            failures++;
            $display("[TB] FAIL add_idle: got busy=%b drops=%0d, expected 0 0", bus.busy, drop_cnt - d0);
        end
    endtask

    task automatic test_bad_opcode;
        int s0, d0;
        s0 = start_cnt; d0 = drop_cnt; tx_q.delete();
        send_byte(8'h07);
        wait_tx(1, "badop");
        settle(15);
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hEE) begin
            failures++;
            $display("[TB] FAIL badop_tx: got %0d bytes first=%h, expected 1 byte ee",
                     tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
        end
        checks++;
        if (drop_cnt - d0 != 1 || start_cnt != s0) begin
            failures++;
            $display("[TB] FAIL badop_pulses: got drops=%0d starts=%0d, expected 1 0",
                     drop_cnt - d0, start_cnt - s0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL badop_busy: got %b, expected 0", bus.busy);
        end
    endtask

    task automatic test_timeout;
        int s0, d0;
        logic [7:0] exp[4];
        exp = '{8'h40, 8'h00, 8'h00, 8'h00};
        s0 = start_cnt; d0 = drop_cnt;
        send_byte(8'h02); send_byte(8'h3F); send_byte(8'h80);
        settle(1100);
        checks++;
        if (drop_cnt - d0 != 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_abort: got drops=%0d busy=%b, expected 1 0",
                     drop_cnt - d0, bus.busy);
        end
        checks++;
        if (bus.fpu_a !== 32'h3F80_0000 || start_cnt != s0) begin
            failures++;
            $display("[TB] FAIL timeout_keep_a: got a=%h starts=%0d, expected 3f800000 0",
                     bus.fpu_a, start_cnt - s0);
        end
        tx_q.delete();
        send_frame(8'h03, 32'h4080_0000, 32'h4000_0000);
        settle(2);
        checks++;
        if (bus.fpu_op !== DIV || bus.fpu_a !== 32'h4080_0000 || bus.fpu_b !== 32'h4000_0000 ||
            start_cnt - s0 != 1) begin
            failures++;
            $display("[TB] FAIL timeout_next_frame: got op=%0d a=%h b=%h starts=%0d, expected 3 40800000 40000000 1",
                     bus.fpu_op, bus.fpu_a, bus.fpu_b, start_cnt - s0);
        end
        fpu_reply(32'h4000_0000);
        wait_tx(4, "div");
        settle(15);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("[TB] FAIL div_tx_byte%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_rx_error;
        int s0, d0;
        logic [7:0] exp[4];
        exp = '{8'h40, 8'h00, 8'h00, 8'h00};
        s0 = start_cnt; d0 = drop_cnt;
        send_byte(8'h00); send_byte(8'h3F); send_byte(8'h80);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        @(posedge clk); #1 bus.rx_err = 1'b1;
        @(posedge clk); #1 bus.rx_err = 1'b0;
        settle(4);
        checks++;
        if (drop_cnt - d0 != 1 || start_cnt != s0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rxerr_abort: got drops=%0d starts=%0d busy=%b, expected 1 0 0",
                     drop_cnt - d0, start_cnt - s0, bus.busy);
        end
        checks++;
        if (bus.fpu_b !== 32'h4000_0000) begin
            failures++;
            $display("[TB] FAIL rxerr_keep_b: got %h, expected 40000000", bus.fpu_b);
        end
        tx_q.delete();
        send_frame(8'h01, 32'h4040_0000, 32'h3F80_0000);
        settle(2);
        checks++;
        if (bus.fpu_op !== SUB || bus.fpu_a !== 32'h4040_0000 || bus.fpu_b !== 32'h3F80_0000 ||
            start_cnt - s0 != 1) begin
            failures++;
            $display("[TB] FAIL rxerr_next_frame: got op=%0d a=%h b=%h starts=%0d, expected 1 40400000 3f800000 1",
                     bus.fpu_op, bus.fpu_a, bus.fpu_b, start_cnt - s0);
        end
        fpu_reply(32'h4000_0000);
        wait_tx(4, "sub");
        settle(15);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("[TB] FAIL sub_tx_byte%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_bytes_during_wait;
        int s0, d0;
        logic [7:0] exp[4];
        exp = '{8'hC0, 8'h00, 8'h00, 8'h00};
        s0 = start_cnt; d0 = drop_cnt; tx_q.delete();
        send_frame(8'h02, 32'h4000_0000, 32'hBF80_0000);
        settle(2);
        send_byte(8'h55);
        send_byte(8'hAA);
        settle(2);
        checks++;
        if (drop_cnt - d0 != 2 || bus.busy !== 1'b1 || start_cnt - s0 != 1 || tx_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL wait_drops: got drops=%0d busy=%b starts=%0d tx=%0d, expected 2 1 1 0",
                     drop_cnt - d0, bus.busy, start_cnt - s0, tx_q.size());
        end
        checks++;
        if (bus.fpu_op !== MUL || bus.fpu_b !== 32'hBF80_0000) begin
            failures++;
            $display("[TB] FAIL mul_operands: got op=%0d b=%h, expected 2 bf800000", bus.fpu_op, bus.fpu_b);
        end
        fpu_reply(32'hC000_0000);
        wait_tx(4, "mul");
        settle(15);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("[TB] FAIL mul_tx_byte%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_tx;
        int s0;
        logic [7:0] exp[4];
        exp = '{8'h40, 8'h40, 8'h00, 8'h00};
        tx_q.delete();
        send_frame(8'h00, 32'h3F80_0000, 32'h3F80_0000);
        fpu_reply(32'h4000_0000);
        wait_tx(2, "reset_mid");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.tx_en, bus.fpu_start, bus.busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got tx_en/start/busy=%b, expected 000",
                     {bus.tx_en, bus.fpu_start, bus.busy});
        end
        checks++;
        if (bus.fpu_a !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midreset_fpu_a: got %h, expected 0", bus.fpu_a);
        end
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        settle(10);
        checks++;
        if (tx_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL midreset_no_resume: got %0d bytes, expected 2", tx_q.size());
        end
        s0 = start_cnt; tx_q.delete();
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000);
        settle(2);
        checks++;
        if (start_cnt - s0 != 1 || bus.fpu_a !== 32'h3F80_0000 || bus.fpu_b !== 32'h4000_0000) begin
            failures++;
            $display("[TB] FAIL postreset_frame: got starts=%0d a=%h b=%h, expected 1 3f800000 40000000",
                     start_cnt - s0, bus.fpu_a, bus.fpu_b);
        end
        fpu_reply(32'h4040_0000);
        wait_tx(4, "postreset");
        settle(15);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got;
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("[TB] FAIL postreset_tx_byte%0d: got %h, expected %h", i, got, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_frame();
        test_bad_opcode();
        test_timeout();
        test_rx_error();
        test_bytes_during_wait();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
